// File: rtl/spi_fetch_arbiter_pkg.sv
// Shared constants and encodings for the SPI flash fetch/data-read arbiter.
package spi_fetch_arbiter_pkg;

  localparam logic [7:0] SPI_OP_READ = 8'h03;
  localparam logic [5:0] NBITS_FETCH = 6'd48;
  localparam logic [5:0] NBITS_DATA  = 6'd40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_DR
  } grant_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit sequencer: CLK_DIV divider, sclk phase, 40-bit transmit and
// 16-bit receive shift registers and bit counter for one read transaction.
module spi_shift_engine #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [5:0]  i_nbits,
  input  logic [39:0] i_tx,
  input  logic        i_miso,
  output logic        o_sclk,
  output logic        o_mosi,
  output logic        o_bit_end,
  output logic [5:0]  o_bit_idx,
  output logic        o_done,
  output logic [15:0] o_rx
);

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

  logic        r_active;
  logic        r_phase;
  logic [3:0]  r_div;
  logic [5:0]  r_bit;
  logic [5:0]  r_last;
  logic [39:0] r_tx;
  logic [15:0] r_rx;
  logic        r_done;
  logic        w_half_end;

  assign w_half_end = r_active && (r_div == DIV_MAX);
  assign o_bit_end  = w_half_end && r_phase;
  assign o_sclk     = r_active && r_phase;
  assign o_mosi     = r_tx[39];
  assign o_bit_idx  = r_bit;
  assign o_done     = r_done;
  assign o_rx       = r_rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_last   <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_active) begin
        r_active <= 1'b1;
        r_phase  <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_last   <= i_nbits - 6'd1;
        r_tx     <= i_tx;
        r_rx     <= '0;
      end else if (r_active) begin
        if (!w_half_end) begin
          r_div <= r_div + 4'd1;
        end else begin
          r_div   <= '0;
          r_phase <= ~r_phase;
          // miso is sampled on the edge that ends the high half of each bit
          if (r_phase) begin
            r_rx <= {r_rx[14:0], i_miso};
            r_tx <= {r_tx[38:0], 1'b0};
            if (r_bit == r_last) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_bit <= r_bit + 6'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_fetch_arbiter.sv
// Arbitrates instruction-fetch and data-read ports onto one SPI flash and
// sequences a 0x03 read transaction for the granted port.
module spi_fetch_arbiter
  import spi_fetch_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [23:0] DATA_BASE = 24'h010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ready,
  output logic [15:0] if_rdata,
  input  logic        dr_req,
  input  logic [7:0]  dr_addr,
  output logic        dr_ready,
  output logic [7:0]  dr_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_mosi_oe,
  input  logic        spi_miso
);

  state_t      r_state;
  state_t      w_next;
  grant_t      r_gnt;
  grant_t      w_gnt;
  logic        w_start;
  logic [23:0] w_addr;
  logic [5:0]  w_nbits;
  logic        w_sclk;
  logic        w_mosi;
  logic        w_bit_end;
  logic [5:0]  w_bit_idx;
  logic        w_done;
  logic [15:0] w_rx;
  logic [15:0] r_if_rdata;
  logic [7:0]  r_dr_rdata;

  // r_gnt doubles as last_grant once the transaction finishes
  always_comb begin
    w_gnt = r_gnt;
    if (if_req && dr_req) begin
      w_gnt = (r_gnt == GNT_DR) ? GNT_IF : GNT_DR;
    end else if (if_req) begin
      w_gnt = GNT_IF;
    end else if (dr_req) begin
      w_gnt = GNT_DR;
    end
    w_start = (r_state == ST_IDLE) && (if_req || dr_req);
    w_addr  = (w_gnt == GNT_IF) ? {7'b0, if_addr, 1'b0}
                                : DATA_BASE + {16'b0, dr_addr};
    w_nbits = (w_gnt == GNT_IF) ? NBITS_FETCH : NBITS_DATA;
  end

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_nbits  (w_nbits),
    .i_tx     ({SPI_OP_READ, w_addr, 8'h00}),
    .i_miso   (spi_miso),
    .o_sclk   (w_sclk),
    .o_mosi   (w_mosi),
    .o_bit_end(w_bit_end),
    .o_bit_idx(w_bit_idx),
    .o_done   (w_done),
    .o_rx     (w_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= GNT_DR;
      r_if_rdata <= '0;
      r_dr_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_gnt <= w_gnt;
      // captured on the edge entering DONE so rdata is valid with ready
      if (r_state == ST_DATA && w_done) begin
        if (r_gnt == GNT_IF) r_if_rdata <= w_rx;
        else                 r_dr_rdata <= w_rx[7:0];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    spi_cs_n    = 1'b1;
    spi_mosi_oe = 1'b0;
    busy        = 1'b1;
    if_ready    = 1'b0;
    dr_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = ST_CMD;
      end
      ST_CMD: begin
        spi_cs_n    = 1'b0;
        spi_mosi_oe = 1'b1;
        if (w_bit_end && w_bit_idx == 6'd7) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        spi_cs_n    = 1'b0;
        spi_mosi_oe = 1'b1;
        if (w_bit_end && w_bit_idx == 6'd31) w_next = ST_DATA;
      end
      ST_DATA: begin
        spi_cs_n = 1'b0;
        if (w_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        if_ready = (r_gnt == GNT_IF);
        dr_ready = (r_gnt == GNT_DR);
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign spi_sclk = w_sclk;
  assign spi_mosi = spi_mosi_oe && w_mosi;
  assign if_rdata = r_if_rdata;
  assign dr_rdata = r_dr_rdata;

endmodule

// File: tb/tb_spi_fetch_arbiter.sv
// Directed bench for spi_fetch_arbiter with a behavioural SPI flash per instance.
module tb_spi_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // instance A: CLK_DIV=1, DATA_BASE=FFFFF0
  logic        a_rst, a_if_req, a_dr_req, a_if_ready, a_dr_ready, a_busy;
  logic [15:0] a_if_addr, a_if_rdata;
  logic [7:0]  a_dr_addr, a_dr_rdata;
  logic        a_cs_n, a_sclk, a_mosi, a_oe, a_miso;
  // instance B: CLK_DIV=3, default DATA_BASE
  logic        b_rst, b_if_req, b_dr_req, b_if_ready, b_dr_ready, b_busy;
  logic [15:0] b_if_addr, b_if_rdata;
  logic [7:0]  b_dr_addr, b_dr_rdata;
  logic        b_cs_n, b_sclk, b_mosi, b_oe, b_miso;

  spi_fetch_arbiter #(.CLK_DIV(1), .DATA_BASE(24'hFFFFF0)) u_dut_a (
    .clk(clk), .rst(a_rst), .if_req(a_if_req), .if_addr(a_if_addr),
    .if_ready(a_if_ready), .if_rdata(a_if_rdata), .dr_req(a_dr_req),
    .dr_addr(a_dr_addr), .dr_ready(a_dr_ready), .dr_rdata(a_dr_rdata),
    .busy(a_busy), .spi_cs_n(a_cs_n), .spi_sclk(a_sclk), .spi_mosi(a_mosi),
    .spi_mosi_oe(a_oe), .spi_miso(a_miso)
  );

  spi_fetch_arbiter #(.CLK_DIV(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .if_req(b_if_req), .if_addr(b_if_addr),
    .if_ready(b_if_ready), .if_rdata(b_if_rdata), .dr_req(b_dr_req),
    .dr_addr(b_dr_addr), .dr_ready(b_dr_ready), .dr_rdata(b_dr_rdata),
    .busy(b_busy), .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_mosi_oe(b_oe), .spi_miso(b_miso)
  );

  // flash models: capture first 32 MOSI bits, return resp MSB first after bit 32
  logic [5:0]  fa_cnt = '0, fb_cnt = '0;
  logic [31:0] fa_cap = '0, fb_cap = '0;
  logic [15:0] resp_a = '0, resp_b = '0;
  logic [3:0]  fa_idx, fb_idx;
  int fa_viol = 0, fb_viol = 0, fa_mviol = 0, fb_mviol = 0;
  int a_ifn = 0, a_drn = 0, b_ifn = 0;

  always @(posedge a_sclk or posedge a_cs_n) begin
    if (a_cs_n) fa_cnt <= '0;
    else begin
      if (fa_cnt < 6'd32) fa_cap <= {fa_cap[30:0], a_mosi};
      if ((fa_cnt < 6'd32) != a_oe) fa_viol <= fa_viol + 1;
      fa_cnt <= fa_cnt + 6'd1;
    end
  end
  always @(posedge b_sclk or posedge b_cs_n) begin
    if (b_cs_n) fb_cnt <= '0;
    else begin
      if (fb_cnt < 6'd32) fb_cap <= {fb_cap[30:0], b_mosi};
      if ((fb_cnt < 6'd32) != b_oe) fb_viol <= fb_viol + 1;
      fb_cnt <= fb_cnt + 6'd1;
    end
  end
  assign fa_idx = 4'(6'd48 - fa_cnt);
  assign fb_idx = 4'(6'd48 - fb_cnt);
  assign a_miso = (fa_cnt > 6'd32 && fa_cnt <= 6'd48) ? resp_a[fa_idx] : 1'b0;
  assign b_miso = (fb_cnt > 6'd32 && fb_cnt <= 6'd48) ? resp_b[fb_idx] : 1'b0;

  always @(negedge clk) begin
    if (!a_oe && a_mosi) fa_mviol <= fa_mviol + 1;
    if (!b_oe && b_mosi) fb_mviol <= fb_mviol + 1;
    if (a_if_ready) a_ifn <= a_ifn + 1;
    if (a_dr_ready) a_drn <= a_drn + 1;
    if (b_if_ready) b_ifn <= b_ifn + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs_a(output int cyc);
    cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!a_cs_n) begin cyc = cycle; break; end
    end
  endtask

  task automatic wait_rdy_a(input bit want_if, output int cyc);
    cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (want_if ? a_if_ready : a_dr_ready) begin cyc = cycle; break; end
    end
  endtask

  int c0, c1, c2, crel, n0;
  int glog[4];
  int nlog, rdyc, r2c, gap, mingap;
  bit prev;
  int r1, r2;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_if_req = 1'b0; a_dr_req = 1'b0; a_if_addr = '0; a_dr_addr = '0;
    b_if_req = 1'b0; b_dr_req = 1'b0; b_if_addr = '0; b_dr_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_pins", 32'({a_cs_n, a_sclk, a_mosi, a_oe}), 32'h8);
    check("rst_ready_busy", 32'({a_if_ready, a_dr_ready, a_busy}), 32'h0);
    check("rst_if_rdata", 32'(a_if_rdata), 32'h0);
    check("rst_dr_rdata", 32'(a_dr_rdata), 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // single fetch
    resp_a = 16'hA53C; a_if_addr = 16'h0012; a_if_req = 1'b1;
    wait_cs_a(c0);
    wait_rdy_a(1'b1, c1);
    a_if_req = 1'b0;
    check("fetch_latency", c1 - c0, 97);
    check("fetch_rdata", 32'(a_if_rdata), 32'hA53C);
    check("fetch_cmd_addr", fa_cap, 32'h03000024);
    repeat (4) @(negedge clk);
    check("fetch_if_pulses", a_ifn, 1);
    check("fetch_dr_pulses", a_drn, 0);
    check("fetch_busy_low", 32'(a_busy), 32'h0);

    // data read with address wrap
    resp_a = 16'h5A00; a_dr_addr = 8'hFF; a_dr_req = 1'b1;
    wait_cs_a(c0);
    wait_rdy_a(1'b0, c1);
    a_dr_req = 1'b0;
    check("dr_latency", c1 - c0, 81);
    check("dr_rdata", 32'(a_dr_rdata), 32'h5A);
    check("dr_cmd_addr_wrap", fa_cap, 32'h030000EF);
    check("dr_if_untouched", 32'(a_if_rdata), 32'hA53C);
    repeat (4) @(negedge clk);
    check("dr_pulses", a_drn, 1);

    // both requests held: alternate starting with IF
    resp_a = 16'h6E91; a_if_addr = 16'h0003; a_dr_addr = 8'h10;
    a_if_req = 1'b1; a_dr_req = 1'b1;
    glog = '{default: 0};
    nlog = 0; rdyc = -1; r2c = -1; gap = 0; mingap = 99; prev = 1'b1;
    for (int i = 0; i < 1000 && nlog < 4; i++) begin
      @(negedge clk);
      if (a_cs_n) gap++;
      else begin
        if (prev && rdyc >= 0) begin
          if (gap < mingap) mingap = gap;
          if (r2c < 0) r2c = cycle - rdyc;
        end
        gap = 0;
      end
      prev = a_cs_n;
      if (a_if_ready || a_dr_ready) begin
        glog[nlog] = a_if_ready ? 1 : 2;
        nlog++;
        rdyc = cycle;
      end
    end
    a_if_req = 1'b0; a_dr_req = 1'b0;
    check("alt_order", {8'(glog[0]), 8'(glog[1]), 8'(glog[2]), 8'(glog[3])}, 32'h01020102);
    check("alt_cs_gap", mingap, 2);
    check("alt_ready_to_cs", r2c, 2);
    check("alt_if_rdata", 32'(a_if_rdata), 32'h6E91);
    check("alt_dr_rdata", 32'(a_dr_rdata), 32'h6E);

    // reset mid-ADDR
    repeat (3) @(negedge clk);
    resp_a = 16'h1234; a_if_addr = 16'h0100; a_if_req = 1'b1;
    wait_cs_a(c0);
    repeat (24) @(negedge clk);
    n0 = a_ifn;
    #2 a_rst = 1'b1;
    #1 check("rst_async_cs_sclk_busy", 32'({a_cs_n, a_sclk, a_busy}), 32'h4);
    @(negedge clk);
    check("rst_mid_if_rdata", 32'(a_if_rdata), 32'h0);
    check("rst_mid_dr_rdata", 32'(a_dr_rdata), 32'h0);
    repeat (3) @(negedge clk);
    check("rst_no_ready", a_ifn - n0, 0);
    a_rst = 1'b0;
    crel = cycle;
    wait_cs_a(c1);
    check("rst_regrant", c1 - crel, 1);
    wait_rdy_a(1'b1, c2);
    a_if_req = 1'b0;
    check("rst_refetch_latency", c2 - c1, 97);
    check("rst_refetch_rdata", 32'(a_if_rdata), 32'h1234);
    check("rst_refetch_addr", fa_cap, 32'h03000200);

    // request dropped mid-DATA
    repeat (3) @(negedge clk);
    resp_a = 16'hBEEF; a_if_addr = 16'h0ABC; n0 = a_ifn; a_if_req = 1'b1;
    wait_cs_a(c0);
    repeat (70) @(negedge clk);
    a_if_req = 1'b0; a_if_addr = 16'hFFFF;
    wait_rdy_a(1'b1, c1);
    check("drop_latency", c1 - c0, 97);
    check("drop_rdata", 32'(a_if_rdata), 32'hBEEF);
    check("drop_addr_latched", fa_cap, 32'h03001578);
    repeat (6) @(negedge clk);
    check("drop_one_pulse", a_ifn - n0, 1);
    check("drop_busy_low", 32'(a_busy), 32'h0);

    // CLK_DIV=3 fetch
    resp_b = 16'hC3E7; b_if_addr = 16'h8001; b_if_req = 1'b1;
    c0 = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!b_cs_n) begin c0 = cycle; break; end
    end
    r1 = -1; r2 = -1; c1 = -1; prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (b_sclk && !prev) begin
        if (r1 < 0) r1 = cycle;
        else if (r2 < 0) r2 = cycle;
      end
      prev = b_sclk;
      if (b_if_ready) begin c1 = cycle; break; end
    end
    b_if_req = 1'b0;
    check("div3_sclk_period", r2 - r1, 6);
    check("div3_latency", c1 - c0, 289);
    check("div3_rdata", 32'(b_if_rdata), 32'hC3E7);
    check("div3_cmd_addr", fb_cap, 32'h03010002);
    repeat (4) @(negedge clk);
    check("div3_pulses", b_ifn, 1);

    check("oe_phase_violations", fa_viol + fb_viol, 0);
    check("mosi_when_oe_low", fa_mviol + fb_mviol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
